// File: rtl/vpu_pkg.sv
// Shared opcode/state encodings and sizing defaults for the vector lane sequencer.
package vpu_pkg;

    localparam int unsigned VLEN_MAX_DEF = 8;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_MAX  = 4'd7,
        OP_MIN  = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd11;
    endfunction

endpackage

// File: rtl/vpu_lane_seq.sv
// Sequences one vector op element-by-element through an external 16-bit ALU,
// collecting results into vd and per-element gt flags into cmp_mask.
module vpu_lane_seq
    import vpu_pkg::*;
#(
    parameter int unsigned VLEN_MAX = VLEN_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic [3:0]              vlen,
    input  logic                    vs2_scalar,
    input  logic [16*VLEN_MAX-1:0]  vs1,
    input  logic [16*VLEN_MAX-1:0]  vs2,
    output logic                    alu_enable,
    output logic                    addsel,
    output logic                    subsel,
    output logic                    andsel,
    output logic                    orsel,
    output logic                    xorsel,
    output logic                    sltsel,
    output logic                    maxsel,
    output logic                    minsel,
    output logic                    mulsel,
    output logic                    srasel,
    output logic                    srlsel,
    output logic                    sllsel,
    output logic [15:0]             ds1,
    output logic [15:0]             ds2,
    input  logic [15:0]             alu_data_rd,
    input  logic                    gt,
    input  logic                    eq,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*VLEN_MAX-1:0]  vd,
    output logic [VLEN_MAX-1:0]     cmp_mask,
    output logic                    err
);

    localparam int unsigned IW = (VLEN_MAX > 1) ? $clog2(VLEN_MAX) : 1;
    localparam int unsigned LW = $clog2(VLEN_MAX + 1);

    state_e                  state_q, state_d;
    op_e                     op_q;
    logic [16*VLEN_MAX-1:0]  vs1_q, vs2_q, vd_q;
    logic [VLEN_MAX-1:0]     cmp_q;
    logic                    scalar_q;
    logic                    err_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           len_eff;
    logic [IW-1:0]           idx_q;
    logic                    last_elem;
    logic [15:0]             wr_data;

    // Out-of-range lengths (0 or beyond the lane count) run the full vector.
    always_comb begin
        if (vlen == 4'd0 || 32'(vlen) > VLEN_MAX)
            len_eff = LW'(VLEN_MAX);
        else
            len_eff = LW'(vlen);
    end

    assign last_elem = (32'(idx_q) + 32'd1) == 32'(len_q);
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign vd        = vd_q;
    assign cmp_mask  = cmp_q;
    assign err       = err_q;
    assign mulsel    = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = op_legal(op) ? S_EXEC : S_DONE;
            S_EXEC: if (last_elem) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addsel = 1'b0;
        subsel = 1'b0;
        andsel = 1'b0;
        orsel  = 1'b0;
        xorsel = 1'b0;
        sltsel = 1'b0;
        maxsel = 1'b0;
        minsel = 1'b0;
        srasel = 1'b0;
        srlsel = 1'b0;
        sllsel = 1'b0;
        ds1    = '0;
        ds2    = '0;
        if (state_q == S_EXEC) begin
            ds1 = vs1_q[16*idx_q +: 16];
            ds2 = scalar_q ? vs2_q[15:0] : vs2_q[16*idx_q +: 16];
            case (op_q)
                OP_ADD:  addsel = 1'b1;
                OP_SUB:  subsel = 1'b1;
                OP_AND:  andsel = 1'b1;
                OP_OR:   orsel  = 1'b1;
                OP_XOR:  xorsel = 1'b1;
                OP_SLT:  sltsel = 1'b1;
                OP_MAX:  maxsel = 1'b1;
                OP_MIN:  minsel = 1'b1;
                OP_SLL:  sllsel = 1'b1;
                OP_SRL:  srlsel = 1'b1;
                OP_SRA:  srasel = 1'b1;
                default: ;
            endcase
        end
        alu_enable = addsel | subsel | andsel | orsel | xorsel | sltsel |
                     maxsel | minsel | srasel | srlsel | sllsel;
    end

    // SLT is derived from the comparator flags rather than the ALU data path.
    assign wr_data = (op_q == OP_SLT) ? {15'd0, (!gt && !eq)} : alu_data_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_PASS;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            vd_q     <= '0;
            cmp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_e'(op);
                        vs1_q    <= vs1;
                        vs2_q    <= vs2;
                        scalar_q <= vs2_scalar;
                        len_q    <= len_eff;
                        idx_q    <= '0;
                        vd_q     <= '0;
                        cmp_q    <= '0;
                        err_q    <= !op_legal(op);
                    end
                end
                S_EXEC: begin
                    vd_q[16*idx_q +: 16] <= wr_data;
                    cmp_q[idx_q]         <= gt;
                    idx_q                <= idx_q + IW'(1);
                end
                S_DONE: begin
                    if (out_ready)
                        err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_lane_seq.sv
// Directed bench for vpu_lane_seq with a behavioural ALU16 and a result scoreboard.
module tb_vpu_lane_seq;

    localparam int VM = 8;
    localparam int W  = 16 * VM;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [3:0]     op, vlen;
    logic           vs2_scalar;
    logic [W-1:0]   vs1, vs2;
    logic           alu_enable, addsel, subsel, andsel, orsel, xorsel, sltsel;
    logic           maxsel, minsel, mulsel, srasel, srlsel, sllsel;
    logic [15:0]    ds1, ds2, alu_data_rd;
    logic           gt, eq;
    logic           out_valid, out_ready;
    logic [W-1:0]   vd;
    logic [VM-1:0]  cmp_mask;
    logic           err;

    int total = 0;
    int bad   = 0;
    logic in_err_test  = 1'b0;
    logic err_sel_seen = 1'b0;
    logic scalar_test  = 1'b0;

    typedef struct {
        logic [W-1:0]  vd;
        logic [VM-1:0] cm;
        logic          err;
        int            lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    vpu_lane_seq #(.VLEN_MAX(VM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .vlen(vlen), .vs2_scalar(vs2_scalar), .vs1(vs1), .vs2(vs2),
        .alu_enable(alu_enable), .addsel(addsel), .subsel(subsel), .andsel(andsel),
        .orsel(orsel), .xorsel(xorsel), .sltsel(sltsel), .maxsel(maxsel),
        .minsel(minsel), .mulsel(mulsel), .srasel(srasel), .srlsel(srlsel),
        .sllsel(sllsel), .ds1(ds1), .ds2(ds2), .alu_data_rd(alu_data_rd),
        .gt(gt), .eq(eq), .out_valid(out_valid), .out_ready(out_ready),
        .vd(vd), .cmp_mask(cmp_mask), .err(err)
    );

    // Behavioural ALU16: signed compare, shift amount from ds2[3:0].
    always_comb begin
        gt = $signed(ds1) > $signed(ds2);
        eq = ds1 == ds2;
        if (addsel)      alu_data_rd = ds1 + ds2;
        else if (subsel) alu_data_rd = ds1 - ds2;
        else if (andsel) alu_data_rd = ds1 & ds2;
        else if (orsel)  alu_data_rd = ds1 | ds2;
        else if (xorsel) alu_data_rd = ds1 ^ ds2;
        else if (sltsel) alu_data_rd = {15'd0, $signed(ds1) < $signed(ds2)};
        else if (maxsel) alu_data_rd = ($signed(ds1) > $signed(ds2)) ? ds1 : ds2;
        else if (minsel) alu_data_rd = ($signed(ds1) < $signed(ds2)) ? ds1 : ds2;
        else if (sllsel) alu_data_rd = ds1 << ds2[3:0];
        else if (srlsel) alu_data_rd = ds1 >> ds2[3:0];
        else if (srasel) alu_data_rd = 16'($signed(ds1) >>> ds2[3:0]);
        else             alu_data_rd = ds1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd7:  return ($signed(a) > $signed(b)) ? a : b;
            4'd8:  return ($signed(a) < $signed(b)) ? a : b;
            4'd9:  return a << b[3:0];
            4'd10: return a >> b[3:0];
            4'd11: return 16'($signed(a) >>> b[3:0]);
            default: return a;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [10:0] sels;
        sels = {addsel, subsel, andsel, orsel, xorsel, sltsel, maxsel, minsel, srasel, srlsel, sllsel};
        chk("mulsel_low", W'(mulsel), W'(0));
        chk("sel_onehot", W'($onehot0(sels)), W'(1));
        chk("enable_vs_sel", W'(|sels), W'(alu_enable));
        if (in_err_test && (|sels || alu_enable)) err_sel_seen = 1'b1;
        if (scalar_test && alu_enable) chk("ds2_scalar", W'(ds2), W'(16'd4));
    end

    task automatic do_op(input logic [3:0] o, input logic [3:0] vl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sc, input int hold);
        exp_t e, g;
        int   len, lat;
        logic [15:0] ea, eb;
        len = (vl == 0 || vl > VM) ? VM : int'(vl);
        e.vd = '0; e.cm = '0;
        e.err = (o > 4'd11);
        e.lat = e.err ? 0 : len;
        if (!e.err) begin
            for (int i = 0; i < len; i++) begin
                ea = a[16*i +: 16];
                eb = sc ? b[15:0] : b[16*i +: 16];
                e.vd[16*i +: 16] = ref_op(o, ea, eb);
                e.cm[i] = $signed(ea) > $signed(eb);
            end
        end
        sbq.push_back(e);

        @(negedge clk);
        chk("in_ready_idle", W'(in_ready), W'(1));
        op = o; vlen = vl; vs1 = a; vs2 = b; vs2_scalar = sc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_reached", W'(out_valid), W'(1));
        g = sbq.pop_front();
        chk("latency", W'(lat), W'(g.lat));
        chk("vd", vd, g.vd);
        chk("cmp_mask", W'(cmp_mask), W'(g.cm));
        chk("err", W'(err), W'(g.err));

        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; op = 4'd1;
            @(posedge clk); #1;
            chk("hold_out_valid", W'(out_valid), W'(1));
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_vd", vd, g.vd);
            chk("hold_cmp", W'(cmp_mask), W'(g.cm));
            chk("hold_err", W'(err), W'(g.err));
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_out_valid", W'(out_valid), W'(0));
        chk("post_hs_in_ready", W'(in_ready), W'(1));
        chk("post_hs_err", W'(err), W'(0));
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [3:0] ops [9];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; vlen = '0;
        vs2_scalar = 1'b0; vs1 = '0; vs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_vd", vd, W'(0));
        chk("rst_alu_enable", W'(alu_enable), W'(0));
        chk("rst_ds", W'({ds1, ds2}), W'(0));
        rst = 1'b0;

        // ADD vlen=4
        a = '0; b = '0;
        a[15:0] = 16'd1; a[31:16] = 16'd2; a[47:32] = 16'd3; a[63:48] = 16'hFFFF;
        for (int i = 0; i < VM; i++) b[16*i +: 16] = 16'd1;
        do_op(4'd1, 4'd4, a, b, 1'b0, 0);

        // SLT vlen=2
        a = '0; b = '0;
        a[15:0] = 16'h8000; a[31:16] = 16'd5; b[15:0] = 16'd1; b[31:16] = 16'd5;
        do_op(4'd6, 4'd2, a, b, 1'b0, 0);

        // SLL scalar broadcast
        a = '0; b = '0;
        for (int i = 0; i < VM; i++) begin
            a[16*i +: 16] = 16'h0001;
            b[16*i +: 16] = 16'(16'h0100 + i);
        end
        b[15:0] = 16'd4;
        scalar_test = 1'b1;
        do_op(4'd9, 4'd8, a, b, 1'b1, 0);
        scalar_test = 1'b0;

        // Illegal opcode
        err_sel_seen = 1'b0;
        in_err_test  = 1'b1;
        do_op(4'd13, 4'd3, a, b, 1'b0, 0);
        in_err_test  = 1'b0;
        chk("illegal_no_select", W'(err_sel_seen), W'(0));

        // Back-pressure in DONE, vlen=0 treated as full length
        for (int i = 0; i < VM; i++) begin
            a[16*i +: 16] = 16'($urandom);
            b[16*i +: 16] = 16'($urandom);
        end
        do_op(4'd2, 4'd0, a, b, 1'b0, 5);

        // vlen beyond lane count
        do_op(4'd5, 4'd12, a, b, 1'b0, 0);

        ops = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd10, 4'd11, 4'd2, 4'd1, 4'd6};
        foreach (ops[j]) begin
            for (int i = 0; i < VM; i++) begin
                a[16*i +: 16] = 16'($urandom);
                b[16*i +: 16] = 16'($urandom);
            end
            do_op(ops[j], 4'($urandom_range(1, 8)), a, b, 1'($urandom_range(0, 1)), 0);
        end

        // Reset while in EXEC at idx=3
        a = '0; b = '0;
        for (int i = 0; i < VM; i++) begin
            a[16*i +: 16] = 16'(16'h0010 + i);
            b[16*i +: 16] = 16'd2;
        end
        @(negedge clk);
        op = 4'd1; vlen = 4'd8; vs1 = a; vs2 = b; vs2_scalar = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", W'(in_ready), W'(0));
        chk("pre_rst_vd_el2", W'(vd[47:32]), W'(16'h0014));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vd", vd, W'(0));
        chk("async_rst_cmp", W'(cmp_mask), W'(0));
        chk("async_rst_in_ready", W'(in_ready), W'(1));
        chk("async_rst_alu", W'({alu_enable, ds1, ds2}), W'(0));
        chk("async_rst_out_valid", W'(out_valid), W'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_valid_after_rst", W'(out_valid), W'(0));
        end
        chk("idle_after_rst", W'(in_ready), W'(1));
        do_op(4'd1, 4'd8, a, b, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
